// File: rtl/regfile_4x_onehot.sv
`default_nettype none
// ============================================================================
// Module   : regfile_4x_onehot
// Purpose  : Four-entry register file that sits directly after a 2-to-4
//            register-select decoder. The decoder's one-hot output is used
//            as the write select. Writes whose select is not one-hot are
//            blocked and raise the sticky sel_err flag. Two read ports
//            return registered data one cycle after rd_en.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            wr_en      - write request
//            wr_sel     - one-hot write select (bit i selects reg i)
//            wr_data    - write data
//            rd_en      - read request for both ports
//            rd_addr_a  - read address, port A
//            rd_addr_b  - read address, port B
//            rd_data_a  - registered read data, port A
//            rd_data_b  - registered read data, port B
//            rd_valid   - one-cycle pulse, read data updated this cycle
//            reg_valid  - bit i set once reg i has been written since reset
//            sel_err    - sticky flag, non-one-hot write attempted
//            clr_err    - synchronous clear of sel_err (a new error wins)
// Options  : REGFILE_WR_BYPASS_EN - when defined, a read that hits the
//            register being written on the same edge returns the new data.
//            When undefined, the read returns the old contents.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_4x_onehot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic [3:0]        reg_valid,
  output logic              sel_err,
  input  logic              clr_err
);

  localparam int c_NUM_REGS = 4;

  logic [DATA_W-1:0] r_regs [c_NUM_REGS];
  logic [3:0]        r_reg_valid;
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_rd_valid;
  logic              r_sel_err;

  logic              w_onehot_ok;
  logic              w_wr_fire;
  logic              w_wr_bad;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves 0.
  assign w_onehot_ok = (wr_sel != 4'b0000) && ((wr_sel & (wr_sel - 4'd1)) == 4'b0000);
  assign w_wr_fire   = wr_en & w_onehot_ok;
  assign w_wr_bad    = wr_en & ~w_onehot_ok;

  // Storage and written-once flags. A blocked write leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_reg_valid <= 4'b0000;
    end else if (w_wr_fire) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          r_regs[i]      <= wr_data;
          r_reg_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Read data selection. The bypass only applies to a valid one-hot write,
  // so a malformed select can never leak wr_data onto a read port.
  always_comb begin
    w_rd_a = r_regs[rd_addr_a];
    w_rd_b = r_regs[rd_addr_b];
`ifdef REGFILE_WR_BYPASS_EN
    if (w_wr_fire && wr_sel[rd_addr_a]) begin
      w_rd_a = wr_data;
    end
    if (w_wr_fire && wr_sel[rd_addr_b]) begin
      w_rd_b = wr_data;
    end
`endif
  end

  // Read port registers: data holds when rd_en is low, valid is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data_a <= w_rd_a;
        r_rd_data_b <= w_rd_b;
      end
    end
  end

  // Sticky select error. Setting takes priority over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_wr_bad) begin
      r_sel_err <= 1'b1;
    end else if (clr_err) begin
      r_sel_err <= 1'b0;
    end
  end

  assign rd_data_a = r_rd_data_a;
  assign rd_data_b = r_rd_data_b;
  assign rd_valid  = r_rd_valid;
  assign reg_valid = r_reg_valid;
  assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_4x_onehot.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_4x_onehot
// Purpose  : Self-checking bench for regfile_4x_onehot. Read expectations
//            are pushed to a scoreboard queue when rd_en is driven and
//            popped when the DUT raises rd_valid. Storage, reg_valid and
//            sel_err are tracked by a small reference model.
// Options  : REGFILE_WR_BYPASS_EN - selects the matching read-during-write
//            expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_4x_onehot;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [3:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [1:0]        rd_addr_a;
  logic [1:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic [3:0]        reg_valid;
  logic              sel_err;
  logic              clr_err;

  regfile_4x_onehot #(.DATA_W(DATA_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .reg_valid (reg_valid),
    .sel_err   (sel_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0]   m_regs [4];
  logic [3:0]          m_rv;
  logic                m_err;
  logic [DATA_W-1:0]   m_last_a;
  logic [DATA_W-1:0]   m_last_b;
  logic [2*DATA_W-1:0] r_sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_rv     = 4'b0000;
    m_err    = 1'b0;
    m_last_a = '0;
    m_last_b = '0;
    r_sb_q.delete();
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_sel  = 4'b0000;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ".rd_data_a"}, 32'(rd_data_a), 32'(m_last_a));
    chk({tag, ".rd_data_b"}, 32'(rd_data_b), 32'(m_last_b));
    chk({tag, ".reg_valid"}, 32'(reg_valid), 32'(m_rv));
    chk({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
  endtask

  // One clock: derive expectations from current inputs, advance the model,
  // clock the DUT, then compare just after the edge.
  task automatic tick(input string tag);
    logic [DATA_W-1:0] ea, eb;
    logic good, bad, exp_rv;
    good = wr_en && ($countones(wr_sel) == 1);
    bad  = wr_en && ($countones(wr_sel) != 1);
    exp_rv = rd_en;
    if (rd_en) begin
      ea = m_regs[rd_addr_a];
      eb = m_regs[rd_addr_b];
`ifdef REGFILE_WR_BYPASS_EN
      if (good && wr_sel[rd_addr_a]) ea = wr_data;
      if (good && wr_sel[rd_addr_b]) eb = wr_data;
`endif
      r_sb_q.push_back({ea, eb});
    end
    if (good) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          m_regs[i] = wr_data;
          m_rv[i]   = 1'b1;
        end
      end
    end
    if (clr_err) m_err = 1'b0;
    if (bad)     m_err = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rv));
    if (rd_valid) begin
      if (r_sb_q.size() == 0) begin
        chk({tag, ".sb_underflow"}, 32'(r_sb_q.size()), 32'd1);
      end else begin
        {m_last_a, m_last_b} = r_sb_q.pop_front();
      end
    end
    check_flags(tag);
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [DATA_W-1:0] d, input string tag);
    idle();
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick(tag);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [1:0] b, input string tag);
    idle();
    rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
    tick(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_addr_a = 2'd0;
    rd_addr_b = 2'd0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    check_flags("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. Read of never-written registers returns zero.
    do_read(2'd0, 2'd3, "t1_read");

    // 2. Write all four registers, then read them back in pairs.
    do_write(4'b0001, 8'hA5, "t2_w0");
    do_write(4'b0010, 8'h3C, "t2_w1");
    do_write(4'b0100, 8'h7E, "t2_w2");
    do_write(4'b1000, 8'hFF, "t2_w3");
    do_read(2'd0, 2'd1, "t2_r01");
    do_read(2'd2, 2'd3, "t2_r23");
    do_read(2'd2, 2'd2, "t2_same");

    // 3. Malformed selects are blocked and flagged; clear and set-wins.
    do_write(4'b0011, 8'h55, "t3_multi");
    do_read(2'd0, 2'd1, "t3_chk01");
    idle(); clr_err = 1'b1; tick("t3_clr");
    do_write(4'b0000, 8'h55, "t3_zero");
    do_write(4'b1111, 8'h55, "t3_all");
    idle(); clr_err = 1'b1; wr_en = 1'b1; wr_sel = 4'b0110; wr_data = 8'h55;
    tick("t3_setwins");
    idle(); wr_sel = 4'b1111; tick("t3_wr_en0");
    idle(); clr_err = 1'b1; tick("t3_clr2");
    do_read(2'd2, 2'd3, "t3_chk23");

    // 4. Read during write on the same register.
    idle();
    wr_en = 1'b1; wr_sel = 4'b0010; wr_data = 8'h99;
    rd_en = 1'b1; rd_addr_a = 2'd1; rd_addr_b = 2'd0;
    tick("t4_rdw");
    do_read(2'd1, 2'd1, "t4_after");
    // A malformed write that covers the read address must not forward.
    idle();
    wr_en = 1'b1; wr_sel = 4'b0011; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
    tick("t4_badfwd");
    idle(); clr_err = 1'b1; tick("t4_clr");

    // 5. Held data while idle, then continuous rd_valid.
    do_read(2'd3, 2'd0, "t5_read");
    for (int i = 0; i < 3; i++) begin
      idle(); rd_addr_a = 2'(i); rd_addr_b = 2'(i + 1);
      tick($sformatf("t5_hold%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      do_read(2'(i + 1), 2'(3 - i), $sformatf("t5_b2b%0d", i));
    end

    // 6. Asynchronous reset between clock edges during a write.
    idle();
    wr_en = 1'b1; wr_sel = 4'b0100; wr_data = 8'hC3;
    rd_en = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async.rd_valid", 32'(rd_valid), 32'd0);
    check_flags("t6_async");
    #1;
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i += 2) begin
      do_read(2'(i), 2'(i + 1), $sformatf("t6_post%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
